// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state enum, the PC increment and the bubble word.
package if_fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_e;

   localparam logic [31:0] PC_INC   = 32'd4;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding
// request over imem req/gnt/rvalid, holds a word across stalls, squashes
// wrong-path responses after redirects, and feeds the IF/ID register.
// Ports: clk, reset (async, active-high); stall, redirect_valid/pc from
// hazard/branch logic; imem_req/addr/gnt/rvalid/rdata to memory;
// pcf/if_instr/if_valid/ifid_load to IF/ID.
// Optional FETCH_STATS_EN adds fetch_count and squash_count outputs.
module if_fetch_unit
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pcf,
   output logic [31:0] if_instr,
   output logic        if_valid,
   output logic        ifid_load
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] squash_count
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  hold_q, hold_d;
   logic         deliver;
   logic         squash;

   // A delivery is suppressed whenever a redirect arrives: the word
   // belongs to the old path.
   always_comb begin
      deliver = 1'b0;
      if (!redirect_valid) begin
         deliver = (state_q == S_HOLD) ||
                   ((state_q == S_WAIT) && imem_rvalid);
      end
   end

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = {pc_q[31:2], 2'b00};
   assign pcf       = pc_q + PC_INC;
   assign if_valid  = deliver;
   assign ifid_load = !stall;

   always_comb begin
      if_instr = NOP_INSTR;
      if (deliver) begin
         if_instr = (state_q == S_HOLD) ? hold_q : imem_rdata;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      squash  = 1'b0;
      if (redirect_valid) begin
         pc_d = redirect_pc & ~32'h3;
         unique case (state_q)
            S_REQ:  state_d = imem_gnt ? S_DROP : S_REQ;
            S_WAIT: begin
               state_d = imem_rvalid ? S_REQ : S_DROP;
               squash  = imem_rvalid;
            end
            S_HOLD: begin
               state_d = S_REQ;
               squash  = 1'b1;
            end
            S_DROP: begin
               state_d = imem_rvalid ? S_REQ : S_DROP;
               squash  = imem_rvalid;
            end
            default: state_d = S_REQ;
         endcase
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (stall) begin
                     hold_d  = imem_rdata;
                     state_d = S_HOLD;
                  end else begin
                     pc_d    = pc_q + PC_INC;
                     state_d = S_REQ;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  pc_d    = pc_q + PC_INC;
                  state_d = S_REQ;
               end
            end
            S_DROP: begin
               if (imem_rvalid) begin
                  state_d = S_REQ;
                  squash  = 1'b1;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         hold_q  <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] squash_count_q, squash_count_d;

   always_comb begin
      fetch_count_d  = fetch_count_q;
      squash_count_d = squash_count_q;
      if (deliver && !stall) fetch_count_d = fetch_count_q + 32'd1;
      if (squash) squash_count_d = squash_count_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count_q  <= 32'd0;
         squash_count_q <= 32'd0;
      end else begin
         fetch_count_q  <= fetch_count_d;
         squash_count_q <= squash_count_d;
      end
   end

   assign fetch_count  = fetch_count_q;
   assign squash_count = squash_count_q;
`else
   logic unused_squash;
   assign unused_squash = squash;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit.
// Drives one vector per cycle and checks the combinational outputs.
module tb_if_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pcf;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        ifid_load;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [31:0] squash_count;
`endif

   int checks = 0;
   int errors = 0;

   if_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .pcf            (pcf),
      .if_instr       (if_instr),
      .if_valid       (if_valid),
      .ifid_load      (ifid_load)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count    (fetch_count),
      .squash_count   (squash_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        rv;
      logic [31:0] rpc;
      logic        g;
      logic        rvl;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_val;
      logic [31:0] e_instr;
      logic [31:0] e_pcf;
   } vec_t;

   localparam int NV = 28;
   vec_t v [NV];

   function automatic vec_t mk(
      input logic st, input logic rv, input logic [31:0] rpc,
      input logic g, input logic rvl, input logic [31:0] rd,
      input logic er, input logic [31:0] ea, input logic ev,
      input logic [31:0] ei, input logic [31:0] ep);
      vec_t t;
      t.st = st; t.rv = rv; t.rpc = rpc;
      t.g = g; t.rvl = rvl; t.rd = rd;
      t.e_req = er; t.e_addr = ea; t.e_val = ev;
      t.e_instr = ei; t.e_pcf = ep;
      return t;
   endfunction

   task automatic check(input string name,
                        input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      stall          = t.st;
      redirect_valid = t.rv;
      redirect_pc    = t.rpc;
      imem_gnt       = t.g;
      imem_rvalid    = t.rvl;
      imem_rdata     = t.rd;
   endtask

   initial begin
      //          st rv rpc           g  rvl rd            req addr         val instr         pcf
      v[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h4);
      v[1]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h4);
      v[2]  = mk(0, 0, 32'h0,        0, 1, 32'h20010005, 0, 32'h0,        1, 32'h20010005, 32'h4);
      v[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h8);
      v[4]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h8);
      v[5]  = mk(1, 0, 32'h0,        0, 1, 32'h8C020000, 0, 32'h4,        1, 32'h8C020000, 32'h8);
      v[6]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h4,        1, 32'h8C020000, 32'h8);
      v[7]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h4,        1, 32'h8C020000, 32'h8);
      v[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h4,        1, 32'h8C020000, 32'h8);
      v[9]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8,        0, 32'h0,        32'hC);
      v[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,        0, 32'h0,        32'hC);
      v[11] = mk(0, 1, 32'h100,      0, 0, 32'h0,        0, 32'h8,        0, 32'h0,        32'hC);
      v[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100,      0, 32'h0,        32'h104);
      v[13] = mk(0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h100,      0, 32'h0,        32'h104);
      v[14] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h104);
      v[15] = mk(0, 1, 32'h200,      0, 1, 32'h12345678, 0, 32'h100,      0, 32'h0,        32'h104);
      v[16] = mk(0, 1, 32'h103,      1, 0, 32'h0,        1, 32'h200,      0, 32'h0,        32'h204);
      v[17] = mk(0, 0, 32'h0,        0, 1, 32'hAAAAAAAA, 0, 32'h100,      0, 32'h0,        32'h104);
      v[18] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h104);
      v[19] = mk(0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h104);
      v[20] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        32'h0);
      v[21] = mk(0, 0, 32'h0,        0, 1, 32'h08000000, 0, 32'hFFFFFFFC, 1, 32'h08000000, 32'h0);
      v[22] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h4);
      v[23] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h4);
      v[24] = mk(1, 0, 32'h0,        0, 1, 32'h11111111, 0, 32'h0,        1, 32'h11111111, 32'h4);
      v[25] = mk(1, 1, 32'h40,       0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4);
      v[26] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h40,       0, 32'h0,        32'h44);
      v[27] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h40,       0, 32'h0,        32'h44);

      reset = 1'b1;
      drive(v[0]);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(v[i]);
         #1;
         check($sformatf("vec%0d", i),
               {29'd0, imem_req, if_valid, ifid_load,
                imem_addr, if_instr, pcf},
               {29'd0, v[i].e_req, v[i].e_val, !v[i].st,
                v[i].e_addr, v[i].e_instr, v[i].e_pcf});
`ifdef FETCH_STATS_EN
         if (i == 13)
            check("squash_after_drop", {96'd0, squash_count}, 128'd0);
         if (i == 14)
            check("squash_one", {96'd0, squash_count}, 128'd1);
`endif
         @(posedge clk);
         #1;
      end

`ifdef FETCH_STATS_EN
      check("fetch_count", {96'd0, fetch_count}, 128'd3);
      check("squash_count", {96'd0, squash_count}, 128'd4);
`endif

      // Now in S_WAIT at 0x40; reset asynchronously mid-cycle.
      stall = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
      check("wait_before_reset", {127'd0, imem_req}, 128'd0);
      #2 reset = 1'b1;
      #1;
      check("reset_async",
            {62'd0, imem_req, if_valid, imem_addr, pcf},
            {62'd0, 1'b1, 1'b0, 32'h0, 32'h4});
`ifdef FETCH_STATS_EN
      check("reset_counters", {64'd0, fetch_count, squash_count}, 128'd0);
`endif
      @(posedge clk);
      #1 reset = 1'b0;
      // A stale response after reset must be ignored in S_REQ.
      imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
      #1;
      check("stale_rvalid",
            {63'd0, imem_req, if_valid, if_instr, imem_addr},
            {63'd0, 1'b1, 1'b0, 32'h0, 32'h0});
      imem_rvalid = 1'b0;
      @(posedge clk);
      #1;
      check("stays_req", {95'd0, imem_req, imem_addr}, {95'd0, 1'b1, 32'h0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
